// File: rtl/mure_pkg.sv
// mure_pkg: shared types for the trace-encoder connector.
//   itype_e     - instruction type produced by the itype detector
//   block_t     - closed instruction block {iaddr, iretire, ilastsize, itype}
//   is_trap()   - true for itypes whose instruction does not retire
// Optional macro ITYPE_BLOCK_TIMESTAMP_EN adds a 64-bit timestamp to block_t.
package mure_pkg;

    localparam int unsigned XLEN_DEFAULT        = 64;
    localparam int unsigned IRETIRE_LEN_DEFAULT = 8;
    localparam int unsigned ITYPE_LEN           = 3;

    typedef enum logic [ITYPE_LEN-1:0] {
        ITYPE_NONE       = 3'd0,
        ITYPE_EXC        = 3'd1,
        ITYPE_INT        = 3'd2,
        ITYPE_ERET       = 3'd3,
        ITYPE_NT_BRANCH  = 3'd4,
        ITYPE_T_BRANCH   = 3'd5,
        ITYPE_UNINF_JUMP = 3'd6
    } itype_e;

    typedef struct packed {
`ifdef ITYPE_BLOCK_TIMESTAMP_EN
        logic [63:0]                    timestamp;
`endif
        logic [XLEN_DEFAULT-1:0]        iaddr;
        logic [IRETIRE_LEN_DEFAULT-1:0] iretire;
        logic                           ilastsize;
        itype_e                         itype;
    } block_t;

    function automatic logic is_trap(input itype_e t);
        return (t == ITYPE_EXC) || (t == ITYPE_INT);
    endfunction

endpackage

// File: rtl/block_fifo.sv
// block_fifo: generic synchronous FIFO with registered storage.
//   clk, rst - clock, synchronous active-high reset
//   push     - write request; accepted when not full, or when full and
//              a pop happens in the same cycle
//   wdata    - data written on an accepted push
//   pop      - consumer takes the head (ignored while empty)
//   full     - no free entry
//   valid    - head holds data
//   head     - current head entry, all zeros while empty
module block_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output logic full,
    output logic valid,
    output T     head
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        empty;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid   = !empty;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/itype_block_builder.sv
// itype_block_builder: groups retired instructions into E-Trace style
// instruction blocks and buffers closed blocks for the encoder.
//   clk_i, rst_i    - clock, synchronous active-high reset
//   trace_enable_i  - tracing enabled; dropping it flushes the open block
//   commit_valid_i  - one instruction retires or traps this cycle
//   iaddr_i         - address of the committing instruction
//   compressed_i    - 1 = 16-bit instruction
//   itype_i         - detector itype for this commit
//   time_i          - timestamp source (only with ITYPE_BLOCK_TIMESTAMP_EN)
//   block_valid_o   - FIFO head valid
//   block_ready_i   - consumer accepts the head
//   block_o         - head block
//   overflow_o      - sticky: a closed block was dropped on a full FIFO
// Optional macro: ITYPE_BLOCK_TIMESTAMP_EN.
module itype_block_builder
    import mure_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned IRETIRE_LEN = IRETIRE_LEN_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            trace_enable_i,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] iaddr_i,
    input  logic            compressed_i,
    input  itype_e          itype_i,
`ifdef ITYPE_BLOCK_TIMESTAMP_EN
    input  logic [63:0]     time_i,
`endif
    output logic            block_valid_o,
    input  logic            block_ready_i,
    output block_t          block_o,
    output logic            overflow_o
);

    typedef enum logic {IDLE, OPEN} state_e;

    localparam logic [IRETIRE_LEN:0] SAT_LIMIT =
        (IRETIRE_LEN+1)'((2 ** IRETIRE_LEN) - 2);

    state_e                 state, state_next;
    logic [IRETIRE_LEN-1:0] counter, counter_next;
    logic [XLEN-1:0]        start_addr, start_next;
    logic                   last_size, last_next;

    logic                   accepted;
    logic [XLEN-1:0]        base_addr;
    logic [IRETIRE_LEN-1:0] base_count;
    logic                   base_last;
    logic [IRETIRE_LEN:0]   inc;
    logic [IRETIRE_LEN:0]   sum;

    logic                   push;
    block_t                 blk;
    logic                   fifo_full;

    assign accepted = commit_valid_i && trace_enable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            counter    <= '0;
            start_addr <= '0;
            last_size  <= 1'b0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            start_addr <= start_next;
            last_size  <= last_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        start_next   = start_addr;
        last_next    = last_size;
        push         = 1'b0;
        blk          = '0;
        base_addr    = start_addr;
        base_count   = counter;
        base_last    = last_size;

        // An instruction arriving in IDLE opens the block and is then
        // processed exactly like one arriving in OPEN.
        if (state == IDLE) begin
            base_addr  = iaddr_i;
            base_count = '0;
            base_last  = 1'b0;
        end

        inc = compressed_i ? (IRETIRE_LEN+1)'(1) : (IRETIRE_LEN+1)'(2);
        sum = {1'b0, base_count} + inc;

`ifdef ITYPE_BLOCK_TIMESTAMP_EN
        blk.timestamp = time_i;
`endif

        if (state == OPEN && !trace_enable_i) begin
            push          = 1'b1;
            blk.iaddr     = start_addr;
            blk.iretire   = counter;
            blk.ilastsize = last_size;
            blk.itype     = ITYPE_NONE;
            counter_next  = '0;
            state_next    = IDLE;
        end else if (accepted) begin
            if (is_trap(itype_i)) begin
                // Trapping instruction does not retire: count and last
                // size come from what retired before it.
                push          = 1'b1;
                blk.iaddr     = base_addr;
                blk.iretire   = base_count;
                blk.ilastsize = base_last;
                blk.itype     = itype_i;
                counter_next  = '0;
                state_next    = IDLE;
            end else if (itype_i != ITYPE_NONE || sum >= SAT_LIMIT) begin
                push          = 1'b1;
                blk.iaddr     = base_addr;
                blk.iretire   = sum[IRETIRE_LEN-1:0];
                blk.ilastsize = !compressed_i;
                blk.itype     = itype_i;
                counter_next  = '0;
                state_next    = IDLE;
            end else begin
                counter_next = sum[IRETIRE_LEN-1:0];
                last_next    = !compressed_i;
                start_next   = base_addr;
                state_next   = OPEN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (push && fifo_full && !(block_valid_o && block_ready_i)) begin
            overflow_o <= 1'b1;
        end
    end

    block_fifo #(
        .T     (block_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (blk),
        .pop   (block_ready_i),
        .full  (fifo_full),
        .valid (block_valid_o),
        .head  (block_o)
    );

endmodule

// File: tb/tb_itype_block_builder.sv
`timescale 1ns/1ps
module tb_itype_block_builder;
    import mure_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_enable;
    logic        commit_valid;
    logic [63:0] iaddr;
    logic        compressed;
    itype_e      itype;
    logic        block_valid;
    logic        block_ready;
    block_t      block;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;

    block_t      exp_q[$];
    block_t      obs_q[$];

    always #5 clk = ~clk;

`ifdef ITYPE_BLOCK_TIMESTAMP_EN
    logic [63:0] time_val = '0;
    always @(posedge clk) time_val <= time_val + 64'd1;
`endif

    itype_block_builder #(
        .XLEN        (64),
        .IRETIRE_LEN (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .trace_enable_i (trace_enable),
        .commit_valid_i (commit_valid),
        .iaddr_i        (iaddr),
        .compressed_i   (compressed),
        .itype_i        (itype),
`ifdef ITYPE_BLOCK_TIMESTAMP_EN
        .time_i         (time_val),
`endif
        .block_valid_o  (block_valid),
        .block_ready_i  (block_ready),
        .block_o        (block),
        .overflow_o     (overflow)
    );

    function automatic block_t strip(input block_t b);
        block_t r;
        r = b;
`ifdef ITYPE_BLOCK_TIMESTAMP_EN
        r.timestamp = '0;
`endif
        return r;
    endfunction

    function automatic block_t mk(input logic [63:0] a, input int unsigned r,
                                  input logic l, input itype_e t);
        block_t b;
        b           = '0;
        b.iaddr     = a;
        b.iretire   = 8'(r);
        b.ilastsize = l;
        b.itype     = t;
        return b;
    endfunction

    // Capture every block the consumer accepts.
    always @(negedge clk) begin
        if (!rst && block_valid && block_ready) obs_q.push_back(strip(block));
    end

    task automatic commit(input logic [63:0] a, input logic c, input itype_e t);
        commit_valid = 1'b1;
        iaddr        = a;
        compressed   = c;
        itype        = t;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        iaddr        = '0;
        compressed   = 1'b0;
        itype        = ITYPE_NONE;
    endtask

    // Bounded wait for n captured blocks, plus a few cycles to expose extras.
    task automatic wait_obs(input int n);
        int budget;
        budget = 300;
        while (obs_q.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        trace_enable = 1'b1;
        commit_valid = 1'b1;
        iaddr        = 64'hDEAD_0000;
        compressed   = 1'b0;
        itype        = ITYPE_T_BRANCH;
        block_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (block_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", block_valid);
        end
        checks++;
        if (block !== '0) begin
            failures++; $display("FAIL reset_block got=%h want=0", block);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL reset_overflow got=%b want=0", overflow);
        end
        commit_valid = 1'b0;
        itype        = ITYPE_NONE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs_q.delete();
    endtask

    task automatic test_basic;
        block_t e, o;
        for (int i = 0; i < 4; i++) commit(64'h8000_0000 + 64'(4 * i), 1'b0, ITYPE_NONE);
        @(negedge clk);
        checks++;
        if (block_valid !== 1'b0) begin
            failures++; $display("FAIL basic_early got=%b want=0", block_valid);
        end
        e = mk(64'h8000_0000, 10, 1'b1, ITYPE_T_BRANCH);
        exp_q.push_back(e);
        commit(64'h8000_0010, 1'b0, ITYPE_T_BRANCH);
        @(negedge clk);
        checks++;
        if (block_valid !== 1'b1 || strip(block) !== e) begin
            failures++;
            $display("FAIL basic_latency got valid=%b blk=%h want valid=1 blk=%h",
                     block_valid, strip(block), e);
        end
        wait_obs(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL basic_block got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_traps;
        block_t e, o;
        commit(64'h100, 1'b1, ITYPE_NONE);
        commit(64'h102, 1'b1, ITYPE_NONE);
        exp_q.push_back(mk(64'h100, 2, 1'b0, ITYPE_EXC));
        commit(64'h104, 1'b1, ITYPE_EXC);
        commit(64'h2000, 1'b0, ITYPE_NONE);
        exp_q.push_back(mk(64'h2000, 3, 1'b0, ITYPE_UNINF_JUMP));
        commit(64'h2004, 1'b1, ITYPE_UNINF_JUMP);
        exp_q.push_back(mk(64'h3000, 0, 1'b0, ITYPE_INT));
        commit(64'h3000, 1'b0, ITYPE_INT);
        commit(64'h3100, 1'b0, ITYPE_NONE);
        exp_q.push_back(mk(64'h3100, 2, 1'b1, ITYPE_INT));
        commit(64'h3104, 1'b0, ITYPE_INT);
        exp_q.push_back(mk(64'h3200, 1, 1'b0, ITYPE_ERET));
        commit(64'h3200, 1'b1, ITYPE_ERET);
        exp_q.push_back(mk(64'h3300, 2, 1'b1, ITYPE_NT_BRANCH));
        commit(64'h3300, 1'b0, ITYPE_NT_BRANCH);
        wait_obs(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL traps_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL traps_block got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation;
        block_t e, o;
        exp_q.push_back(mk(64'h4000, 254, 1'b1, ITYPE_NONE));
        exp_q.push_back(mk(64'h4000 + 64'(127 * 4), 254, 1'b1, ITYPE_NONE));
        for (int i = 0; i < 254; i++) commit(64'h4000 + 64'(4 * i), 1'b0, ITYPE_NONE);
        // 252 + 1 stays open, the next compressed one reaches the limit.
        for (int i = 0; i < 126; i++) commit(64'h9000 + 64'(4 * i), 1'b0, ITYPE_NONE);
        commit(64'h9000 + 64'd504, 1'b1, ITYPE_NONE);
        exp_q.push_back(mk(64'h9000, 254, 1'b0, ITYPE_NONE));
        commit(64'h9000 + 64'd506, 1'b1, ITYPE_NONE);
        wait_obs(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL sat_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL sat_block got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        block_t e, o;
        block_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(64'hA000 + 64'(16 * i), 2, 1'b1, ITYPE_T_BRANCH));
            commit(64'hA000 + 64'(16 * i), 1'b0, ITYPE_T_BRANCH);
        end
        // Full FIFO: push and pop in the same cycle must both succeed.
        block_ready = 1'b1;
        exp_q.push_back(mk(64'hA040, 1, 1'b0, ITYPE_T_BRANCH));
        commit(64'hA040, 1'b1, ITYPE_T_BRANCH);
        wait_obs(exp_q.size());
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL b2b_overflow got=%b want=0", overflow);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL b2b_block got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow;
        block_t e, o, first;
        block_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(mk(64'hB000 + 64'(16 * i), 2, 1'b1, ITYPE_T_BRANCH));
            commit(64'hB000 + 64'(16 * i), 1'b0, ITYPE_T_BRANCH);
        end
        first = exp_q[0];
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_flag got=%b want=1", overflow);
        end
        checks++;
        if (block_valid !== 1'b1 || strip(block) !== first) begin
            failures++;
            $display("FAIL ovf_head got valid=%b blk=%h want valid=1 blk=%h",
                     block_valid, strip(block), first);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (strip(block) !== first) begin
            failures++; $display("FAIL ovf_stable got=%h want=%h", strip(block), first);
        end
        block_ready = 1'b1;
        wait_obs(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL ovf_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL ovf_block got=%h want=%h", o, e); end
        end
        checks++;
        if (overflow !== 1'b1 || block_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky got ovf=%b valid=%b want ovf=1 valid=0", overflow, block_valid);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flush;
        block_t e, o;
        commit(64'h5000, 1'b1, ITYPE_NONE);
        commit(64'h5002, 1'b1, ITYPE_NONE);
        commit(64'h5004, 1'b1, ITYPE_NONE);
        e = mk(64'h5000, 3, 1'b0, ITYPE_NONE);
        exp_q.push_back(e);
        trace_enable = 1'b0;
        commit_valid = 1'b1;
        iaddr        = 64'h5006;
        itype        = ITYPE_T_BRANCH;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (block_valid !== 1'b1 || strip(block) !== e) begin
            failures++;
            $display("FAIL flush_latency got valid=%b blk=%h want valid=1 blk=%h",
                     block_valid, strip(block), e);
        end
        for (int i = 0; i < 8; i++) begin
            iaddr = 64'h5100 + 64'(4 * i);
            itype = (i % 2 == 0) ? ITYPE_EXC : ITYPE_NONE;
            @(posedge clk);
        end
        #1;
        commit_valid = 1'b0;
        itype        = ITYPE_NONE;
        trace_enable = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(64'h6000, 2, 1'b1, ITYPE_T_BRANCH));
        commit(64'h6000, 1'b0, ITYPE_T_BRANCH);
        wait_obs(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL flush_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL flush_block got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_block;
        block_t e, o;
        // overflow is still set from the overflow scenario
        block_ready = 1'b0;
        commit(64'hC000, 1'b0, ITYPE_T_BRANCH);
        commit(64'hC010, 1'b0, ITYPE_T_BRANCH);
        for (int i = 0; i < 3; i++) commit(64'hC100 + 64'(4 * i), 1'b0, ITYPE_NONE);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (block_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state got valid=%b ovf=%b want valid=0 ovf=0", block_valid, overflow);
        end
        exp_q.delete(); obs_q.delete();
        block_ready = 1'b1;
        commit(64'hD000, 1'b0, ITYPE_NONE);
        exp_q.push_back(mk(64'hD000, 3, 1'b0, ITYPE_T_BRANCH));
        commit(64'hD004, 1'b1, ITYPE_T_BRANCH);
        wait_obs(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rstmid_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL rstmid_block got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_traps();
        test_saturation();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/itype_block_builder.md
Name: itype_block_builder

Overview:
- Sits directly downstream of the itype detector in the CVA6 trace-encoder connector.
- Takes the per-instruction commit stream plus the itype the detector produced for it. Accumulates retired instructions into instruction blocks, as in the E-Trace ingress model.
- A block closes on each discontinuity; closed blocks are buffered in a small FIFO and handed to the encoder with a valid/ready handshake.

Parameters:
- XLEN, 64, width of instruction addresses.
- IRETIRE_LEN, 8, width of the half-word retire counter.
- FIFO_DEPTH, 4, closed-block entries buffered; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- trace_enable_i  in  1  tracing enabled; a falling edge flushes the open block.
- commit_valid_i  in  1  one instruction retires or takes a trap this cycle.
- iaddr_i  in  XLEN  address of the committing instruction.
- compressed_i  in  1  1 = 16-bit instruction, 0 = 32-bit.
- itype_i  in  ITYPE_LEN  itype_e from the detector, same cycle as commit_valid_i.
- block_valid_o  out  1  FIFO head valid.
- block_ready_i  in  1  consumer accepts the head.
- block_o  out  $bits(block_t)  {iaddr, iretire, ilastsize, itype} of the head.
- overflow_o  out  1  sticky: a closed block was dropped because the FIFO was full.

Behaviour:
- Reset values: block_valid_o=0, block_o=0, overflow_o=0, FIFO empty, FSM=IDLE, counter=0. Reset mid-block discards the open block with no output.
- FSM states:
  - IDLE: no open block.
  - OPEN: block accumulating.
- Accepted instruction: commit_valid_i && trace_enable_i.
- IDLE + accepted instruction:
  - Latch start_addr=iaddr_i; go to OPEN.
  - The same instruction is then processed as below.
- Increment per instruction: inc = compressed_i ? 1 : 2 half-words; ilastsize = !compressed_i.
- Retiring itypes (NONE, NT_BRANCH, T_BRANCH, UNINF_JUMP, ERET):
  - counter += inc.
  - If itype != NONE, close with that itype and go to IDLE.
- EXC / INT: the instruction does not retire, so the counter is unchanged. Close with the current count (may be 0) and that itype, then go to IDLE.
- Saturation: if an itype-NONE instruction brings counter ≥ 2^IRETIRE_LEN − 2, close with itype NONE, including that instruction.
- trace_enable_i falling while OPEN: close next cycle with itype NONE and the current count; go to IDLE.
- Close action: push {start_addr, counter, ilastsize of last retired instr, itype} into the FIFO; clear counter in the same cycle.
- Latency: a closed block appears on block_o the cycle after the closing commit (registered FIFO head).
- Handshake:
  - Pop on block_valid_o && block_ready_i.
  - block_o is stable while valid and not ready.
- FIFO full at push:
  - Push and pop in the same cycle: both succeed.
  - Full with no pop: block dropped, overflow_o set, cleared only by rst_i.
- Empty: block_valid_o=0. Push into empty FIFO with ready=1: visible next cycle, popped on that cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty use an extra wrap bit.

Optional Feature:
- Macro: ITYPE_BLOCK_TIMESTAMP_EN.
- When defined:
  - Adds input time_i [63:0].
  - block_t gains a timestamp field, sampled from time_i in the close cycle.
  - For trace_enable_i flushes, the timestamp is sampled in the cycle the flush closes the block.
- When undefined: no port, no field; block_t width excludes the timestamp.

Decomposition:
- mure_pkg holds:
  - itype_e (existing) and ITYPE_LEN.
  - block_t struct.
  - ITYPE_NONE..UNINF_JUMP encodings.
  - IRETIRE_LEN default constant.
- Sub-module block_fifo: generic synchronous FIFO (T, DEPTH), instantiated once; the builder holds only the FSM and counter.

Test Plan:
- Four 32-bit NONE commits from 0x8000_0000, then a T_BRANCH commit → one block {0x8000_0000, iretire=10, ilastsize=1, itype=T_BRANCH} one cycle later.
- Two compressed commits, then EXC → block {iretire=2, ilastsize=0, itype=EXC}; the next commit opens a new block at its own address.
- Continuous NONE 32-bit commits with IRETIRE_LEN=8 → block with itype NONE, iretire=254, every 127 instructions.
- block_ready_i=0, 5 closing commits with FIFO_DEPTH=4 → 4 blocks held, 5th dropped, overflow_o=1. Releasing ready drains 4 blocks in order.
- trace_enable_i drops after 3 compressed NONE commits → block {iretire=3, itype=NONE} next cycle; later commits ignored until re-enable.
- rst_i asserted with an open block of 6 half-words and 2 FIFO entries → next cycle block_valid_o=0, overflow_o=0; the first post-reset block starts at the first new iaddr.
